// File: rtl/seq_code_gen.sv
// seq_code_gen
//   3-bit code sequencer for a 3-to-8 decoder. It has two modes:
//   - free-running: the code advances once every DIV clock cycles;
//   - single-step: in IDLE, each STEP request advances the code once.
//   The code can also be loaded synchronously at any time.
//
// Parameters
//   DIV   : CP cycles per automatic code step (1..255)
//
// Ports
//   CP    in   clock, rising edge
//   CLR   in   synchronous active-high reset
//   START in   enter free-running mode (from IDLE)
//   STOP  in   return to IDLE; an advance due on that edge is dropped
//   STEP  in   single advance, honoured only in IDLE
//   DIR   in   0 = count up, 1 = count down (sampled on the advancing edge)
//   LOAD  in   load LDATA into DATA, restart the prescaler
//   LDATA in   load value
//   DATA  out  current code
//   TICK  out  one-cycle pulse when a new DATA value appears
//   WRAP  out  one-cycle pulse with TICK when the step wrapped 7->0 or 0->7
//   BUSY  out  high while free-running
module seq_code_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic       CP,
   input  logic       CLR,
   input  logic       START,
   input  logic       STOP,
   input  logic       STEP,
   input  logic       DIR,
   input  logic       LOAD,
   input  logic [2:0] LDATA,
   output logic [2:0] DATA,
   output logic       TICK,
   output logic       WRAP,
   output logic       BUSY
);

   localparam int unsigned PS_W = $clog2(DIV) + 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PS_W-1:0] ps_q, ps_d;
   logic [2:0]      data_q, data_d;
   logic            tick_q, tick_d;
   logic            wrap_q, wrap_d;

   // One code step: returns {wrapped, next_code}.
   function automatic logic [3:0] step_code(input logic [2:0] code, input logic down);
      logic [2:0] nxt;
      logic       wrp;
      if (down) begin
         nxt = code - 3'd1;
         wrp = (code == 3'd0);
      end else begin
         nxt = code + 3'd1;
         wrp = (code == 3'd7);
      end
      return {wrp, nxt};
   endfunction

   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      data_d  = data_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;

      // LOAD outranks every mode input and leaves the state alone.
      if (LOAD) begin
         data_d = LDATA;
         ps_d   = '0;
         tick_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (STOP) begin
                  // already idle: nothing to do, but STOP still masks START/STEP
               end else if (START) begin
                  state_d = RUN;
                  ps_d    = '0;
               end else if (STEP) begin
                  {wrap_d, data_d} = step_code(data_q, DIR);
                  tick_d           = 1'b1;
               end
            end
            RUN: begin
               if (STOP) begin
                  state_d = IDLE;
                  ps_d    = '0;
               end else if (ps_q == PS_LAST) begin
                  {wrap_d, data_d} = step_code(data_q, DIR);
                  tick_d           = 1'b1;
                  ps_d             = '0;
               end else begin
                  ps_d = ps_q + PS_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CP) begin
      if (CLR) begin
         state_q <= IDLE;
         ps_q    <= '0;
         data_q  <= 3'b000;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         data_q  <= data_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign DATA = data_q;
   assign TICK = tick_q;
   assign WRAP = wrap_q;
   assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_seq_code_gen.sv
module tb_seq_code_gen;

   logic       CP = 1'b0;
   logic       CLR = 1'b0, START = 1'b0, STOP = 1'b0, STEP = 1'b0;
   logic       DIR = 1'b0, LOAD = 1'b0;
   logic [2:0] LDATA = 3'd0;

   logic [2:0] d4_data, d1_data;
   logic       d4_tick, d4_wrap, d4_busy;
   logic       d1_tick, d1_wrap, d1_busy;

   int checks = 0;
   int errors = 0;

   always #5 CP = ~CP;

   seq_code_gen #(.DIV(4)) dut4 (
      .CP(CP), .CLR(CLR), .START(START), .STOP(STOP), .STEP(STEP),
      .DIR(DIR), .LOAD(LOAD), .LDATA(LDATA),
      .DATA(d4_data), .TICK(d4_tick), .WRAP(d4_wrap), .BUSY(d4_busy)
   );

   seq_code_gen #(.DIV(1)) dut1 (
      .CP(CP), .CLR(CLR), .START(START), .STOP(STOP), .STEP(STEP),
      .DIR(DIR), .LOAD(LOAD), .LDATA(LDATA),
      .DATA(d1_data), .TICK(d1_tick), .WRAP(d1_wrap), .BUSY(d1_busy)
   );

   // advance one clock; outputs are stable 1 ns after the edge
   task automatic cyc();
      @(posedge CP);
      #1;
   endtask

   task automatic test_reset();
      CLR = 1'b1;
      cyc();
      CLR = 1'b0;
      checks++;
      if ({d4_data, d4_tick, d4_wrap, d4_busy} !== 6'b000_0_0_0) begin
         errors++;
         $display("FAIL reset dut4 got data=%0d tick=%b wrap=%b busy=%b exp 0 0 0 0",
                  d4_data, d4_tick, d4_wrap, d4_busy);
      end
      checks++;
      if ({d1_data, d1_tick, d1_wrap, d1_busy} !== 6'b000_0_0_0) begin
         errors++;
         $display("FAIL reset dut1 got data=%0d tick=%b wrap=%b busy=%b exp 0 0 0 0",
                  d1_data, d1_tick, d1_wrap, d1_busy);
      end
   endtask

   task automatic test_run_up();
      logic [2:0] prev, nxt;
      DIR   = 1'b0;
      START = 1'b1;
      cyc();
      START = 1'b0;
      checks++;
      if ({d4_busy, d4_data, d4_tick} !== {1'b1, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL run_start got busy=%b data=%0d tick=%b exp 1 0 0",
                  d4_busy, d4_data, d4_tick);
      end
      for (int k = 1; k <= 8; k++) begin
         prev = 3'(k - 1);
         nxt  = 3'(k);
         for (int j = 0; j < 3; j++) begin
            cyc();
            checks++;
            if ({d4_data, d4_tick, d4_wrap, d4_busy} !== {prev, 1'b0, 1'b0, 1'b1}) begin
               errors++;
               $display("FAIL run_wait k=%0d j=%0d got data=%0d tick=%b wrap=%b busy=%b exp %0d 0 0 1",
                        k, j, d4_data, d4_tick, d4_wrap, d4_busy, prev);
            end
         end
         cyc();
         checks++;
         if ({d4_data, d4_tick, d4_wrap, d4_busy} !== {nxt, 1'b1, (k == 8), 1'b1}) begin
            errors++;
            $display("FAIL run_step k=%0d got data=%0d tick=%b wrap=%b busy=%b exp %0d 1 %0d 1",
                     k, d4_data, d4_tick, d4_wrap, d4_busy, nxt, (k == 8));
         end
      end
      STOP = 1'b1;
      cyc();
      STOP = 1'b0;
      checks++;
      if ({d4_busy, d4_tick, d4_data} !== {1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL run_stop got busy=%b tick=%b data=%0d exp 0 0 0",
                  d4_busy, d4_tick, d4_data);
      end
   endtask

   task automatic test_step_down();
      logic [2:0] exp;
      DIR = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp  = 3'(7 - i);
         STEP = 1'b1;
         cyc();
         STEP = 1'b0;
         checks++;
         if ({d4_data, d4_tick, d4_wrap, d4_busy} !== {exp, 1'b1, (i == 0), 1'b0}) begin
            errors++;
            $display("FAIL step_down i=%0d got data=%0d tick=%b wrap=%b busy=%b exp %0d 1 %0d 0",
                     i, d4_data, d4_tick, d4_wrap, d4_busy, exp, (i == 0));
         end
         cyc();
         checks++;
         if ({d4_data, d4_tick, d4_wrap} !== {exp, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL step_hold i=%0d got data=%0d tick=%b wrap=%b exp %0d 0 0",
                     i, d4_data, d4_tick, d4_wrap, exp);
         end
      end
      DIR = 1'b0;
   endtask

   task automatic test_stop_at_last();
      // DATA is 5 here; PS reaches DIV-1 after three more edges
      START = 1'b1;
      cyc();
      START = 1'b0;
      repeat (3) cyc();
      STOP = 1'b1;
      cyc();
      STOP = 1'b0;
      checks++;
      if ({d4_data, d4_tick, d4_busy} !== {3'd5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL stop_last got data=%0d tick=%b busy=%b exp 5 0 0",
                  d4_data, d4_tick, d4_busy);
      end
      cyc();
      checks++;
      if ({d4_data, d4_tick, d4_busy} !== {3'd5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL stop_idle got data=%0d tick=%b busy=%b exp 5 0 0",
                  d4_data, d4_tick, d4_busy);
      end
   endtask

   task automatic test_load_priority();
      // in RUN: LOAD beats STOP/START, stays RUN, prescaler restarts
      START = 1'b1;
      cyc();
      START = 1'b0;
      cyc();
      LOAD = 1'b1; LDATA = 3'd2; STOP = 1'b1; START = 1'b1;
      cyc();
      LOAD = 1'b0; STOP = 1'b0; START = 1'b0;
      checks++;
      if ({d4_data, d4_tick, d4_wrap, d4_busy} !== {3'd2, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL load_run got data=%0d tick=%b wrap=%b busy=%b exp 2 1 0 1",
                  d4_data, d4_tick, d4_wrap, d4_busy);
      end
      repeat (3) cyc();
      checks++;
      if ({d4_data, d4_tick} !== {3'd2, 1'b0}) begin
         errors++;
         $display("FAIL load_run_wait got data=%0d tick=%b exp 2 0", d4_data, d4_tick);
      end
      cyc();
      checks++;
      if ({d4_data, d4_tick, d4_busy} !== {3'd3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL load_run_step got data=%0d tick=%b busy=%b exp 3 1 1",
                  d4_data, d4_tick, d4_busy);
      end
      STOP = 1'b1;
      cyc();
      STOP = 1'b0;
      // in IDLE: LOAD beats STOP/START, stays IDLE
      LOAD = 1'b1; LDATA = 3'd5; STOP = 1'b1; START = 1'b1;
      cyc();
      LOAD = 1'b0; STOP = 1'b0; START = 1'b0;
      checks++;
      if ({d4_data, d4_tick, d4_wrap, d4_busy} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load_idle got data=%0d tick=%b wrap=%b busy=%b exp 5 1 0 0",
                  d4_data, d4_tick, d4_wrap, d4_busy);
      end
      cyc();
      checks++;
      if ({d4_data, d4_tick, d4_busy} !== {3'd5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load_after got data=%0d tick=%b busy=%b exp 5 0 0",
                  d4_data, d4_tick, d4_busy);
      end
   endtask

   task automatic test_run_ignore();
      START = 1'b1;
      cyc();
      STEP = 1'b1;
      for (int j = 0; j < 3; j++) begin
         cyc();
         checks++;
         if ({d4_data, d4_tick, d4_busy} !== {3'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ignore_wait j=%0d got data=%0d tick=%b busy=%b exp 5 0 1",
                     j, d4_data, d4_tick, d4_busy);
         end
      end
      cyc();
      START = 1'b0; STEP = 1'b0;
      checks++;
      if ({d4_data, d4_tick} !== {3'd6, 1'b1}) begin
         errors++;
         $display("FAIL ignore_step got data=%0d tick=%b exp 6 1", d4_data, d4_tick);
      end
      STOP = 1'b1;
      cyc();
      STOP = 1'b0;
   endtask

   task automatic test_clr_mid_run();
      // DATA is 6 here
      START = 1'b1;
      cyc();
      START = 1'b0;
      repeat (2) cyc();
      CLR = 1'b1;
      cyc();
      CLR = 1'b0;
      checks++;
      if ({d4_data, d4_busy, d4_tick} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL clr_run got data=%0d busy=%b tick=%b exp 0 0 0",
                  d4_data, d4_busy, d4_tick);
      end
      cyc();
      checks++;
      if ({d4_data, d4_busy, d4_tick} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL clr_next got data=%0d busy=%b tick=%b exp 0 0 0",
                  d4_data, d4_busy, d4_tick);
      end
      START = 1'b1;
      cyc();
      START = 1'b0;
      repeat (3) cyc();
      checks++;
      if ({d4_data, d4_tick} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL clr_restart_wait got data=%0d tick=%b exp 0 0", d4_data, d4_tick);
      end
      cyc();
      checks++;
      if ({d4_data, d4_tick, d4_busy} !== {3'd1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL clr_restart got data=%0d tick=%b busy=%b exp 1 1 1",
                  d4_data, d4_tick, d4_busy);
      end
   endtask

   task automatic test_div1();
      logic [2:0] exp;
      CLR = 1'b1;
      cyc();
      CLR = 1'b0;
      DIR   = 1'b0;
      START = 1'b1;
      cyc();
      START = 1'b0;
      checks++;
      if ({d1_busy, d1_data, d1_tick} !== {1'b1, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL div1_start got busy=%b data=%0d tick=%b exp 1 0 0",
                  d1_busy, d1_data, d1_tick);
      end
      for (int k = 1; k <= 16; k++) begin
         exp = 3'(k);
         cyc();
         checks++;
         if ({d1_data, d1_tick, d1_wrap} !== {exp, 1'b1, (k % 8 == 0)}) begin
            errors++;
            $display("FAIL div1_step k=%0d got data=%0d tick=%b wrap=%b exp %0d 1 %0d",
                     k, d1_data, d1_tick, d1_wrap, exp, (k % 8 == 0));
         end
      end
      CLR = 1'b1;
      cyc();
      CLR = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run_up();
      test_step_down();
      test_stop_at_last();
      test_load_priority();
      test_run_ignore();
      test_clr_mid_run();
      test_div1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_code_gen.md
SEQ_CODE_GEN -- requirements
Module: seq_code_gen

Interface
REQ-001 SHALL have parameter DIV, default 4, the number of CP cycles per automatic code step (legal range 1..255).
REQ-002 SHALL have port CP  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port CLR  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port START  input  1  level sampled each edge; requests free-running mode.
REQ-005 SHALL have port STOP  input  1  level sampled each edge; returns to idle.
REQ-006 SHALL have port STEP  input  1  single advance request, honoured only in IDLE.
REQ-007 SHALL have port DIR  input  1  step direction: 0 = up (+1), 1 = down (-1).
REQ-008 SHALL have port LOAD  input  1  synchronous load of LDATA into DATA.
REQ-009 SHALL have port LDATA  input  3  load value.
REQ-010 SHALL have port DATA  output  3  current 3-bit code; drives the 3-to-8 decoder DATA input.
REQ-011 SHALL have port TICK  output  1  one-cycle pulse, high in the first cycle a new DATA value is presented.
REQ-012 SHALL have port WRAP  output  1  one-cycle pulse coincident with TICK when a step wrapped (7->0 up, 0->7 down).
REQ-013 SHALL have port BUSY  output  1  high while in RUN state.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, RUN; plus an internal prescaler counter PS of width ceil(log2(DIV))+1.
REQ-015 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-016 SHALL resolve simultaneous inputs with priority CLR > LOAD > STOP > START > STEP.
REQ-017 SHALL, on LOAD, set DATA<=LDATA, PS<=0, TICK<=1, WRAP<=0, keep current FSM state.
REQ-018 SHALL, in IDLE with START, move to RUN, PS<=0, no code change that edge.
REQ-019 SHALL, in IDLE with STEP (no higher-priority input), advance DATA once by DIR, pulse TICK (and WRAP if wrapped), stay IDLE.
REQ-020 SHALL, in RUN, increment PS each edge; when PS==DIV-1, advance DATA by DIR modulo 8, PS<=0, pulse TICK, and pulse WRAP if wrapped.
REQ-021 SHALL therefore produce the first automatic advance at the DIV-th edge after the edge that sampled START, then every DIV edges.
REQ-022 SHALL, with DIV=1, advance on every edge in RUN.
REQ-023 SHALL, in RUN with STOP, go to IDLE, PS<=0, and suppress any advance due that edge (TICK=0).
REQ-024 SHALL ignore START in RUN and STEP in RUN (no PS restart, no extra advance).
REQ-025 SHALL sample DIR only on the advancing edge; DIR changes between steps take effect at the next step.
REQ-026 SHALL hold TICK and WRAP low in every cycle not covered by REQ-017/019/020.
REQ-027 SHALL hold DATA, PS and state unchanged in IDLE with no active input.

Reset
REQ-028 SHALL, on CLR sampled high, set state=IDLE, PS=0, DATA=3'b000, TICK=0, WRAP=0, BUSY=0, overriding all other inputs.
REQ-029 SHALL, on CLR asserted mid-RUN, abandon the current prescale interval; no TICK in the reset cycle or the following cycle.

Verification
REQ-030 SHALL cover: CLR 1 cycle, START 1 cycle, DIR=0, DIV=4 -> DATA 0,1,2..7,0 every 4 cycles, TICK per step, WRAP only on 7->0, BUSY=1.
REQ-031 SHALL cover: IDLE, DIR=1, three STEP pulses from DATA=0 -> DATA 7,6,5, WRAP once (0->7), BUSY=0.
REQ-032 SHALL cover: RUN with STOP asserted on the edge where PS==DIV-1 -> no advance, TICK=0, BUSY=0 next cycle, DATA held.
REQ-033 SHALL cover: LOAD=1, LDATA=5 together with STOP and START -> DATA=5, TICK=1, WRAP=0, state unchanged.
REQ-034 SHALL cover: CLR mid-RUN at DATA=6 -> DATA=0, BUSY=0, TICK=0 next cycle; a following START restarts counting from 0.
REQ-035 SHALL cover: DIV=1 instance in RUN, DIR=0 -> DATA changes every cycle, TICK continuously high, WRAP high every 8th cycle.
